// File: rtl/alu_cmd_seq.sv
// alu_cmd_seq: single-outstanding command sequencer driving an external ALU with a 4-entry register file.
// Define ALU_SEQ_MULHI_EN to add the WRHI state that writes the multiply high half to R[rd+1].
module alu_cmd_seq #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [5:0]   cmd_sel,
  input  logic [1:0]   cmd_rd,
  input  logic [1:0]   cmd_ra,
  input  logic [1:0]   cmd_rb,
  input  logic         cmd_imm_en,
  input  logic [N-1:0] cmd_imm,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  output logic [5:0]   alu_sel,
  input  logic [N-1:0] alu_result,
  input  logic [N-1:0] alu_upper_result,
  input  logic         alu_carry_flag,
  input  logic         alu_overflow_flag,
  input  logic         alu_zero_flag,
  input  logic         alu_negative_flag,
  input  logic         alu_parity_flag,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [N-1:0] rsp_data,
  output logic [4:0]   rsp_flags,
  output logic         rsp_err
);
  typedef enum logic [1:0] {IDLE, EXEC, WRHI, RESP} state_t;
  state_t state_q, state_d;
  logic [N-1:0] rf_q [4];
  logic [N-1:0] a_q, b_q, data_q;
  logic [5:0] sel_q;
  logic [1:0] rd_q;
  logic [4:0] flags_q;
  logic err_q, err, load, hi_go;
  logic [N-1:0] res;
  logic [4:0] flg;
  assign err = ((sel_q == 6'd3 || sel_q == 6'd8) && b_q == '0) || (sel_q >= 6'd35 && sel_q <= 6'd62);
  assign load = sel_q == 6'd63;
  assign res = load ? b_q : alu_result;
  assign flg = load ? {2'b00, b_q == '0, 2'b00}
                    : {alu_parity_flag, alu_negative_flag, alu_zero_flag, alu_overflow_flag, alu_carry_flag};
`ifdef ALU_SEQ_MULHI_EN
  logic [N-1:0] hi_q;
  assign hi_go = sel_q == 6'd2 && !err;
`else
  logic unused_hi;
  assign unused_hi = ^alu_upper_result;
  assign hi_go = 1'b0;
`endif
  assign cmd_ready = state_q == IDLE && !rst;
  assign rsp_valid = state_q == RESP && !rst;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign alu_sel = sel_q;
  assign rsp_data = data_q;
  assign rsp_flags = flags_q;
  assign rsp_err = err_q;
  always_comb begin
    state_d = state_q == IDLE ? (cmd_valid ? EXEC : IDLE) :
              state_q == EXEC ? (hi_go ? WRHI : RESP) :
              state_q == WRHI ? RESP :
              (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rf_q <= '{default: '0};
      a_q <= '0;
      b_q <= '0;
      sel_q <= '0;
      rd_q <= '0;
      data_q <= '0;
      flags_q <= '0;
      err_q <= 1'b0;
`ifdef ALU_SEQ_MULHI_EN
      hi_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (cmd_valid && cmd_ready) begin
        a_q <= rf_q[cmd_ra];
        b_q <= cmd_imm_en ? cmd_imm : rf_q[cmd_rb];
        sel_q <= cmd_sel;
        rd_q <= cmd_rd;
      end
      if (state_q == EXEC) begin
        if (!err) rf_q[rd_q] <= res;
        data_q <= err ? '0 : res;
        flags_q <= err ? '0 : flg;
        err_q <= err;
      end
`ifdef ALU_SEQ_MULHI_EN
      if (state_q == EXEC) hi_q <= alu_upper_result;
      if (state_q == WRHI) rf_q[rd_q + 2'd1] <= hi_q;
`endif
    end
  end
endmodule
